lc3_mem_access: RTL and testbench

//  Consumer of the EAB effective address. Runs the LC-3 data-memory access for
//  LD/LDR, LDI, ST/STR and STI over a ready-based memory handshake.

---
 rtl/lc3_mem_if.sv | 28 ++
 rtl/lc3_mem_access.sv | 155 +++++++++++++++
 tb/tb_lc3_mem_access.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_if.sv
// Memory-side bus of the LC-3 data-memory access unit.
// The access unit drives the request side (master); the memory answers (slave).
interface lc3_mem_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_en,
        output mem_we,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_en,
        input  mem_we,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/lc3_mem_access.sv
// LC-3 data-memory access sequencer.
// Consumes the EAB effective address and performs LD/LDR, LDI, ST/STR and STI
// over a ready-based memory handshake. Indirect ops fetch a pointer first and
// then use it unchanged as the final address. A stalled request is abandoned
// after TIMEOUT_CYC cycles without memReady (0 disables the abort).
module lc3_mem_access #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [15:0]       i_eab_out,
    input  logic [15:0]       i_store_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [15:0]       o_mdr_out,
    lc3_mem_if.master         mem
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PTR_REQ = 3'd1;
    localparam logic [2:0] S_MAR_LD  = 3'd2;
    localparam logic [2:0] S_ACC_REQ = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYC);
    localparam logic        LP_TO_EN   = (TIMEOUT_CYC != 0);

    logic [2:0]  r_state;
    logic        r_is_store;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_ptr;
    logic [15:0] r_mdr;
    logic [15:0] r_cnt;
    logic        r_mem_en;
    logic        r_mem_we;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [15:0] w_cnt_next;
    logic        w_timeout;

    // Stall counter increment and abort decision for the current request.
    always_comb begin
        w_cnt_next = r_cnt + 16'd1;
        if (LP_TO_EN && r_mem_en && !mem.mem_ready && (w_cnt_next == LP_TIMEOUT)) begin
            w_timeout = 1'b1;
        end else begin
            w_timeout = 1'b0;
        end
    end

    // Access sequencer: state, bus request registers and completion pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_ptr      <= 16'h0000;
            r_mdr      <= 16'h0000;
            r_cnt      <= 16'h0000;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_addr     <= i_eab_out;
                        r_wdata    <= i_store_data;
                        r_is_store <= i_op[1];
                        r_cnt      <= 16'h0000;
                        r_mem_en   <= 1'b1;
                        r_busy     <= 1'b1;
                        if (i_op[0]) begin
                            // Pointer fetch is always a read.
                            r_mem_we <= 1'b0;
                            r_state  <= S_PTR_REQ;
                        end else begin
                            r_mem_we <= i_op[1];
                            r_state  <= S_ACC_REQ;
                        end
                    end
                end
                S_PTR_REQ: begin
                    if (mem.mem_ready) begin
                        r_ptr    <= mem.mem_rdata;
                        r_mem_en <= 1'b0;
                        r_state  <= S_MAR_LD;
                    end else if (w_timeout) begin
                        r_mem_en <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_MAR_LD: begin
                    r_addr   <= r_ptr;
                    r_mem_en <= 1'b1;
                    r_mem_we <= r_is_store;
                    r_cnt    <= 16'h0000;
                    r_state  <= S_ACC_REQ;
                end
                S_ACC_REQ: begin
                    if (mem.mem_ready) begin
                        if (!r_is_store) begin
                            r_mdr <= mem.mem_rdata;
                        end
                        r_mem_en <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_timeout) begin
                        r_mem_en <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_mdr_out     = r_mdr;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_en    = r_mem_en;
    assign mem.mem_we    = r_mem_we;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed testbench for lc3_mem_access. Instance u_dut uses the default
// timeout; u_dut_to uses TIMEOUT_CYC=4 for the abort scenario.
module tb_lc3_mem_access;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] eab = 16'h0000;
    logic [15:0] sdata = 16'h0000;
    logic        rdy1 = 1'b1;
    logic        rdy2 = 1'b1;

    logic        busy1, done1, err1;
    logic [15:0] mdr1;
    logic        busy2, done2, err2;
    logic [15:0] mdr2;

    logic [15:0] mem [0:65535];
    int          wr_cnt = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    lc3_mem_if bus1 ();
    lc3_mem_if bus2 ();

    lc3_mem_access u_dut (
        .i_clk(clk), .i_reset(reset), .i_start(start1), .i_op(op),
        .i_eab_out(eab), .i_store_data(sdata),
        .o_busy(busy1), .o_done(done1), .o_err(err1), .o_mdr_out(mdr1),
        .mem(bus1)
    );

    lc3_mem_access #(.TIMEOUT_CYC(4)) u_dut_to (
        .i_clk(clk), .i_reset(reset), .i_start(start2), .i_op(op),
        .i_eab_out(eab), .i_store_data(sdata),
        .o_busy(busy2), .o_done(done2), .o_err(err2), .o_mdr_out(mdr2),
        .mem(bus2)
    );

    always #5 clk = ~clk;

    assign bus1.mem_rdata = mem[bus1.mem_addr];
    assign bus1.mem_ready = rdy1;
    assign bus2.mem_rdata = mem[bus2.mem_addr];
    assign bus2.mem_ready = rdy2;

    // Memory model write port for the main instance.
    always @(posedge clk) begin
        if (bus1.mem_en && bus1.mem_ready && bus1.mem_we) begin
            mem[bus1.mem_addr] <= bus1.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr0;
        mem[16'h3005] = 16'hBEEF;
        mem[16'h3010] = 16'h4000;
        mem[16'h4000] = 16'h1234;
        mem[16'h3020] = 16'hFFFF;
        mem[16'hFFFF] = 16'h0000;
        mem[16'h3030] = 16'h0000;
        mem[16'h3040] = 16'h0000;

        // Reset state
        tick(); tick();
        check_val("rst_busy", {31'd0, busy1}, 32'd0);
        check_val("rst_done", {31'd0, done1}, 32'd0);
        check_val("rst_err", {31'd0, err1}, 32'd0);
        check_val("rst_en", {31'd0, bus1.mem_en}, 32'd0);
        check_val("rst_we", {31'd0, bus1.mem_we}, 32'd0);
        check_val("rst_mdr", {16'd0, mdr1}, 32'h0);
        check_val("rst_addr", {16'd0, bus1.mem_addr}, 32'h0);
        check_val("rst_wdata", {16'd0, bus1.mem_wdata}, 32'h0);
        reset = 1'b0;
        tick();

        // 1: direct load; start held through DONE must not requeue
        rdy1 = 1'b1; op = 2'b00; eab = 16'h3005; sdata = 16'h1111; start1 = 1'b1;
        tick();
        check_val("t1_en_c1", {31'd0, bus1.mem_en}, 32'd1);
        check_val("t1_addr_c1", {16'd0, bus1.mem_addr}, 32'h3005);
        check_val("t1_we_c1", {31'd0, bus1.mem_we}, 32'd0);
        check_val("t1_busy_c1", {31'd0, busy1}, 32'd1);
        eab = 16'h3010;
        tick();
        check_val("t1_done_c2", {31'd0, done1}, 32'd1);
        check_val("t1_err_c2", {31'd0, err1}, 32'd0);
        check_val("t1_en_c2", {31'd0, bus1.mem_en}, 32'd0);
        check_val("t1_mdr", {16'd0, mdr1}, 32'hBEEF);
        tick();
        start1 = 1'b0;
        check_val("t1_done_c3", {31'd0, done1}, 32'd0);
        check_val("t1_busy_c3", {31'd0, busy1}, 32'd0);
        check_val("t1_noqueue_en", {31'd0, bus1.mem_en}, 32'd0);
        tick();
        check_val("t1_noqueue_busy", {31'd0, busy1}, 32'd0);

        // 2: load indirect
        op = 2'b01; eab = 16'h3010; sdata = 16'h7777; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_val("t2_en_c1", {31'd0, bus1.mem_en}, 32'd1);
        check_val("t2_addr_c1", {16'd0, bus1.mem_addr}, 32'h3010);
        check_val("t2_we_c1", {31'd0, bus1.mem_we}, 32'd0);
        tick();
        check_val("t2_en_c2", {31'd0, bus1.mem_en}, 32'd0);
        check_val("t2_done_c2", {31'd0, done1}, 32'd0);
        tick();
        check_val("t2_en_c3", {31'd0, bus1.mem_en}, 32'd1);
        check_val("t2_addr_c3", {16'd0, bus1.mem_addr}, 32'h4000);
        check_val("t2_wdata_c3", {16'd0, bus1.mem_wdata}, 32'h7777);
        tick();
        check_val("t2_done_c4", {31'd0, done1}, 32'd1);
        check_val("t2_mdr", {16'd0, mdr1}, 32'h1234);
        tick();

        // 3: store indirect through pointer 0xFFFF
        wr0 = wr_cnt;
        op = 2'b11; eab = 16'h3020; sdata = 16'h00A5; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_val("t3_we_c1", {31'd0, bus1.mem_we}, 32'd0);
        tick();
        tick();
        check_val("t3_en_c3", {31'd0, bus1.mem_en}, 32'd1);
        check_val("t3_addr_c3", {16'd0, bus1.mem_addr}, 32'hFFFF);
        check_val("t3_we_c3", {31'd0, bus1.mem_we}, 32'd1);
        check_val("t3_wdata_c3", {16'd0, bus1.mem_wdata}, 32'h00A5);
        tick();
        check_val("t3_done_c4", {31'd0, done1}, 32'd1);
        check_val("t3_mdr_kept", {16'd0, mdr1}, 32'h1234);
        check_val("t3_mem", {16'd0, mem[16'hFFFF]}, 32'h00A5);
        check_val("t3_wr_cnt", wr_cnt - wr0, 32'd1);
        tick();

        // 4: direct store with memReady low for 5 cycles
        wr0 = wr_cnt;
        rdy1 = 1'b0; op = 2'b10; eab = 16'h3030; sdata = 16'h5A5A; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_val("t4_en", {31'd0, bus1.mem_en}, 32'd1);
            check_val("t4_addr", {16'd0, bus1.mem_addr}, 32'h3030);
            check_val("t4_wdata", {16'd0, bus1.mem_wdata}, 32'h5A5A);
            check_val("t4_we", {31'd0, bus1.mem_we}, 32'd1);
            check_val("t4_nodone", {31'd0, done1}, 32'd0);
            if (i == 5) rdy1 = 1'b1;
            tick();
        end
        check_val("t4_done", {31'd0, done1}, 32'd1);
        check_val("t4_err", {31'd0, err1}, 32'd0);
        check_val("t4_en_off", {31'd0, bus1.mem_en}, 32'd0);
        check_val("t4_mem", {16'd0, mem[16'h3030]}, 32'h5A5A);
        check_val("t4_wr_cnt", wr_cnt - wr0, 32'd1);
        tick();

        // 5: timeout instance; first a good load, then a stuck request
        rdy2 = 1'b1; op = 2'b00; eab = 16'h3005; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        check_val("t5_pre_mdr", {16'd0, mdr2}, 32'hBEEF);
        tick();
        rdy2 = 1'b0; eab = 16'h3040; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("t5_en_hold", {31'd0, bus2.mem_en}, 32'd1);
            check_val("t5_nodone", {31'd0, done2}, 32'd0);
            tick();
        end
        check_val("t5_done", {31'd0, done2}, 32'd1);
        check_val("t5_err", {31'd0, err2}, 32'd1);
        check_val("t5_en_off", {31'd0, bus2.mem_en}, 32'd0);
        check_val("t5_mdr_kept", {16'd0, mdr2}, 32'hBEEF);
        tick();
        check_val("t5_idle", {31'd0, busy2}, 32'd0);
        check_val("t5_err_pulse", {31'd0, err2}, 32'd0);

        // 6: extra starts while busy, then reset during pointer request
        rdy1 = 1'b0; op = 2'b01; eab = 16'h3010; start1 = 1'b1;
        tick();
        op = 2'b10; eab = 16'h3030;
        tick();
        check_val("t6_en_ptr", {31'd0, bus1.mem_en}, 32'd1);
        check_val("t6_addr_ptr", {16'd0, bus1.mem_addr}, 32'h3010);
        check_val("t6_we_ptr", {31'd0, bus1.mem_we}, 32'd0);
        start1 = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t6_en_rst", {31'd0, bus1.mem_en}, 32'd0);
        check_val("t6_busy_rst", {31'd0, busy1}, 32'd0);
        check_val("t6_done_rst", {31'd0, done1}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t6_no_done", {31'd0, done1}, 32'd0);
            check_val("t6_idle_en", {31'd0, bus1.mem_en}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
